// File: rtl/router_pkt_rx.sv
// Router packet receiver.
// Parses header / payload / parity packets, forwards every byte of a routed
// packet through a one-entry holding register to the addressed output FIFO,
// flags parity errors, and silently swallows packets addressed to port 3.
module router_pkt_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    input  logic [7:0] din,
    input  logic [2:0] fifo_full,
    output logic       busy,
    output logic [2:0] we,
    output logic       lfd,
    output logic [7:0] dout,
    output logic       err
);

    // HDR is kept as a reserved encoding; nothing ever enters it.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HDR    = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_DROP   = 3'd4;

    logic [2:0] state_q,      state_d;
    logic [5:0] cnt_q,        cnt_d;
    logic [7:0] xor_q,        xor_d;
    logic       err_q,        err_d;
    logic       hold_valid_q, hold_valid_d;
    logic [7:0] hold_data_q,  hold_data_d;
    logic       hold_lfd_q,   hold_lfd_d;
    logic [1:0] hold_dest_q,  hold_dest_d;

    logic [2:0] dest_oh;
    logic       dest_full;
    logic       stall;
    logic       drain;
    logic       accept;
    logic       load;
    logic       load_lfd;
    logic [1:0] load_dest;

    // Decode the held destination and derive the handshake terms.
    always_comb begin
        dest_oh = 3'b000;
        case (hold_dest_q)
            2'd0:    dest_oh = 3'b001;
            2'd1:    dest_oh = 3'b010;
            2'd2:    dest_oh = 3'b100;
            default: dest_oh = 3'b000;
        endcase
        dest_full = |(fifo_full & dest_oh);
        stall     = hold_valid_q & dest_full;
        drain     = hold_valid_q & ~dest_full;
        accept    = pkt_valid & ~stall;
    end

    // Outputs are forced quiet while reset is asserted so the stale holding
    // register contents never leak out during the reset cycle.
    always_comb begin
        busy = stall & ~rst;
        we   = (drain & ~rst) ? dest_oh : 3'b000;
        lfd  = hold_valid_q & hold_lfd_q & ~rst;
        dout = (hold_valid_q & ~rst) ? hold_data_q : 8'h00;
        err  = err_q & ~rst;
    end

    // Packet FSM: byte counting, running parity, and which bytes get forwarded.
    // hold_dest_q doubles as the packet's destination: it is loaded with the
    // header and keeps its value after the holding register drains.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        xor_d     = xor_q;
        err_d     = 1'b0;
        load      = 1'b0;
        load_lfd  = 1'b0;
        load_dest = hold_dest_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    xor_d = din;
                    cnt_d = din[7:2];
                    if (din[1:0] == 2'd3) begin
                        state_d = ST_DROP;
                    end else begin
                        load      = 1'b1;
                        load_lfd  = 1'b1;
                        load_dest = din[1:0];
                        state_d   = (din[7:2] == 6'd0) ? ST_PARITY : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    load  = 1'b1;
                    xor_d = xor_q ^ din;
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (accept) begin
                    load    = 1'b1;
                    err_d   = (din != xor_q);
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                // len payload bytes plus the parity byte: counter runs len..0.
                if (accept) begin
                    if (cnt_q == 6'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Holding register: a new byte replaces the drained one in the same cycle.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_lfd_d   = hold_lfd_q;
        hold_dest_d  = hold_dest_q;
        if (load) begin
            hold_valid_d = 1'b1;
            hold_data_d  = din;
            hold_lfd_d   = load_lfd;
            hold_dest_d  = load_dest;
        end else if (drain) begin
            hold_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 6'd0;
            xor_q        <= 8'h00;
            err_q        <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= 8'h00;
            hold_lfd_q   <= 1'b0;
            hold_dest_q  <= 2'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            xor_q        <= xor_d;
            err_q        <= err_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_lfd_q   <= hold_lfd_d;
            hold_dest_q  <= hold_dest_d;
        end
    end

endmodule

// File: tb/tb_router_pkt_rx.sv
// Self-checking bench for router_pkt_rx: directed scenarios plus randomized
// packets, compared against a packet-level reference model.
module tb_router_pkt_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       pkt_valid;
    logic [7:0] din;
    logic [2:0] fifo_full;
    logic       busy;
    logic [2:0] we;
    logic       lfd;
    logic [7:0] dout;
    logic       err;

    int checks = 0;
    int errors = 0;

    // Current packet bytes: header, payload, parity.
    logic [7:0] pkt_q[$];
    // Per-cycle output trace.
    logic [2:0] tr_we[$];
    logic [7:0] tr_dout[$];
    logic       tr_lfd[$];
    logic       tr_err[$];
    logic       tr_busy[$];
    // Expected and observed FIFO writes.
    logic [2:0] exp_we[$];
    logic [7:0] exp_d[$];
    logic       exp_l[$];
    int         exp_err;
    logic [2:0] act_we[$];
    logic [7:0] act_d[$];
    logic       act_l[$];
    int         act_err;

    router_pkt_rx dut (
        .clk       (clk),
        .rst       (rst),
        .pkt_valid (pkt_valid),
        .din       (din),
        .fifo_full (fifo_full),
        .busy      (busy),
        .we        (we),
        .lfd       (lfd),
        .dout      (dout),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // One clock cycle: drive inputs, sample settled outputs mid-cycle.
    task automatic tick(input logic v, input logic [7:0] d, input logic [2:0] full,
                        input logic r, output logic acc);
        pkt_valid = v;
        din       = d;
        fifo_full = full;
        rst       = r;
        #2;
        acc = v & ~busy & ~r;
        tr_we.push_back(we);
        tr_dout.push_back(dout);
        tr_lfd.push_back(lfd);
        tr_err.push_back(err);
        tr_busy.push_back(busy);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_trace();
        tr_we.delete(); tr_dout.delete(); tr_lfd.delete(); tr_err.delete(); tr_busy.delete();
        exp_we.delete(); exp_d.delete(); exp_l.delete();
        exp_err = 0;
    endtask

    task automatic build_pkt(input logic [5:0] len, input logic [1:0] addr, input bit bad);
        logic [7:0] x;
        logic [7:0] b;
        pkt_q.delete();
        x = {len, addr};
        pkt_q.push_back(x);
        for (int i = 0; i < int'(len); i++) begin
            b = 8'($urandom);
            x = x ^ b;
            pkt_q.push_back(b);
        end
        pkt_q.push_back(bad ? (x ^ 8'h01) : x);
    endtask

    // Reference model: a routed packet appears byte-for-byte on its FIFO with
    // lfd on the header only; a wrong parity byte costs one err pulse.
    task automatic expect_pkt();
        logic [7:0] x;
        int n;
        n = pkt_q.size();
        if (pkt_q[0][1:0] != 2'd3) begin
            x = 8'h00;
            for (int i = 0; i < n; i++) begin
                exp_we.push_back(3'b001 << pkt_q[0][1:0]);
                exp_d.push_back(pkt_q[i]);
                exp_l.push_back(i == 0);
                if (i < n - 1) x = x ^ pkt_q[i];
            end
            if (x != pkt_q[n-1]) exp_err++;
        end
    endtask

    // Send pkt_q; gaps and random full only when the source is free to idle.
    task automatic send_pkt(input int gap_pct, input int full_pct, input int st_at,
                            input int st_len, input logic [2:0] st_mask);
        int i = 0;
        int t = 0;
        logic acc;
        logic v;
        logic pending = 1'b0;
        logic [2:0] f;
        expect_pkt();
        $display("pkt hdr=%h len=%0d addr=%0d parity=%h", pkt_q[0], pkt_q[0][7:2],
                 pkt_q[0][1:0], pkt_q[pkt_q.size()-1]);
        while (i < pkt_q.size()) begin
            if (t >= 2000) begin
                checks++; errors++;
                $display("FAIL send_timeout got %0d of %0d bytes accepted", i, pkt_q.size());
                break;
            end
            f = 3'b000;
            if (full_pct > 0 && $urandom_range(99) < full_pct) f = 3'($urandom_range(7));
            if (t >= st_at && t < st_at + st_len) f = st_mask;
            v = pending || !(gap_pct > 0 && i > 0 && $urandom_range(99) < gap_pct);
            tick(v, v ? pkt_q[i] : 8'h00, f, 1'b0, acc);
            pending = v & ~acc;
            if (acc) i++;
            t++;
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int k = 0; k < n; k++) tick(1'b0, 8'h00, 3'b000, 1'b0, acc);
    endtask

    task automatic collect();
        act_we.delete(); act_d.delete(); act_l.delete();
        act_err = 0;
        for (int k = 0; k < tr_we.size(); k++) begin
            if (tr_we[k] != 3'b000) begin
                act_we.push_back(tr_we[k]);
                act_d.push_back(tr_dout[k]);
                act_l.push_back(tr_lfd[k]);
            end
            if (tr_err[k]) act_err++;
        end
    endtask

    task automatic test_reset();
        logic acc;
        clear_trace();
        tick(1'b0, 8'h00, 3'b000, 1'b1, acc);
        tick(1'b1, 8'h5A, 3'b111, 1'b1, acc);
        tick(1'b0, 8'hA5, 3'b111, 1'b0, acc);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({tr_busy[k], tr_we[k], tr_lfd[k], tr_dout[k], tr_err[k]} !== 14'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d got busy=%b we=%b lfd=%b dout=%h err=%b want all zero",
                         k, tr_busy[k], tr_we[k], tr_lfd[k], tr_dout[k], tr_err[k]);
            end
        end
    endtask

    task automatic test_good_packet();
        logic [2:0] w;
        clear_trace();
        build_pkt(6'd14, 2'd1, 1'b0);
        send_pkt(0, 0, -1, 0, 3'b000);
        idle(2);
        for (int k = 0; k < 18; k++) begin
            w = (k >= 1 && k <= 16) ? 3'b010 : 3'b000;
            checks++;
            if (tr_we[k] !== w || tr_lfd[k] !== (k == 1) || tr_err[k] !== 1'b0 ||
                (w != 3'b000 && tr_dout[k] !== pkt_q[k-1])) begin
                errors++;
                $display("FAIL good_cycle%0d got we=%b lfd=%b err=%b dout=%h want we=%b lfd=%b err=0 dout=%h",
                         k, tr_we[k], tr_lfd[k], tr_err[k], tr_dout[k], w, (k == 1),
                         (k >= 1 && k <= 16) ? pkt_q[k-1] : 8'h00);
            end
        end
    endtask

    task automatic test_bad_parity();
        clear_trace();
        build_pkt(6'd14, 2'd1, 1'b1);
        send_pkt(0, 0, -1, 0, 3'b000);
        idle(2);
        collect();
        checks++;
        if (act_we.size() !== 16) begin
            errors++;
            $display("FAIL badpar_count got %0d writes want 16", act_we.size());
        end
        for (int k = 0; k < act_we.size() && k < exp_we.size(); k++) begin
            checks++;
            if ({act_we[k], act_d[k], act_l[k]} !== {exp_we[k], exp_d[k], exp_l[k]}) begin
                errors++;
                $display("FAIL badpar_wr%0d got we=%b d=%h lfd=%b want we=%b d=%h lfd=%b",
                         k, act_we[k], act_d[k], act_l[k], exp_we[k], exp_d[k], exp_l[k]);
            end
        end
        for (int k = 0; k < 18; k++) begin
            checks++;
            if (tr_err[k] !== (k == 16)) begin
                errors++;
                $display("FAIL badpar_err cycle %0d got %b want %b", k, tr_err[k], (k == 16));
            end
        end
    endtask

    task automatic test_full_stall();
        clear_trace();
        build_pkt(6'd14, 2'd1, 1'b0);
        send_pkt(0, 0, 6, 3, 3'b010);
        idle(2);
        for (int k = 6; k < 9; k++) begin
            checks++;
            if (tr_busy[k] !== 1'b1 || tr_we[k] !== 3'b000 || tr_dout[k] !== pkt_q[5]) begin
                errors++;
                $display("FAIL stall_cycle%0d got busy=%b we=%b dout=%h want busy=1 we=000 dout=%h",
                         k, tr_busy[k], tr_we[k], tr_dout[k], pkt_q[5]);
            end
        end
        collect();
        checks++;
        if (act_we.size() !== exp_we.size()) begin
            errors++;
            $display("FAIL stall_count got %0d writes want %0d", act_we.size(), exp_we.size());
        end
        for (int k = 0; k < act_we.size() && k < exp_we.size(); k++) begin
            checks++;
            if ({act_we[k], act_d[k], act_l[k]} !== {exp_we[k], exp_d[k], exp_l[k]}) begin
                errors++;
                $display("FAIL stall_wr%0d got we=%b d=%h lfd=%b want we=%b d=%h lfd=%b",
                         k, act_we[k], act_d[k], act_l[k], exp_we[k], exp_d[k], exp_l[k]);
            end
        end
    endtask

    task automatic test_drop();
        int drop_ticks;
        int bad;
        clear_trace();
        build_pkt(6'd3, 2'd3, 1'b0);
        // All FIFOs full: a dropped packet must still flow without back-pressure.
        send_pkt(0, 0, 0, 100, 3'b111);
        drop_ticks = tr_we.size();
        bad = 0;
        for (int k = 0; k < drop_ticks; k++) begin
            if (tr_busy[k] !== 1'b0 || tr_we[k] !== 3'b000 || tr_err[k] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || drop_ticks != 5) begin
            errors++;
            $display("FAIL drop_quiet got %0d bad cycles over %0d cycles want 0 over 5", bad, drop_ticks);
        end
        build_pkt(6'd2, 2'd0, 1'b0);
        send_pkt(0, 0, -1, 0, 3'b000);
        idle(2);
        collect();
        checks++;
        if (act_we.size() !== 4 || act_err !== 0) begin
            errors++;
            $display("FAIL drop_next_count got %0d writes err=%0d want 4 writes err=0", act_we.size(), act_err);
        end
        for (int k = 0; k < act_we.size() && k < exp_we.size(); k++) begin
            checks++;
            if ({act_we[k], act_d[k], act_l[k]} !== {exp_we[k], exp_d[k], exp_l[k]}) begin
                errors++;
                $display("FAIL drop_next_wr%0d got we=%b d=%h lfd=%b want we=%b d=%h lfd=%b",
                         k, act_we[k], act_d[k], act_l[k], exp_we[k], exp_d[k], exp_l[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic acc;
        clear_trace();
        build_pkt(6'd14, 2'd0, 1'b0);
        $display("pkt hdr=%h len=14 addr=0 interrupted by reset", pkt_q[0]);
        for (int k = 0; k < 8; k++) tick(1'b1, pkt_q[k], 3'b000, 1'b0, acc);
        tick(1'b0, 8'h00, 3'b000, 1'b1, acc);
        tick(1'b0, 8'h00, 3'b000, 1'b0, acc);
        for (int k = 8; k < 10; k++) begin
            checks++;
            if ({tr_busy[k], tr_we[k], tr_lfd[k], tr_dout[k], tr_err[k]} !== 14'd0) begin
                errors++;
                $display("FAIL rstmid_cycle%0d got busy=%b we=%b lfd=%b dout=%h err=%b want all zero",
                         k, tr_busy[k], tr_we[k], tr_lfd[k], tr_dout[k], tr_err[k]);
            end
        end
        clear_trace();
        build_pkt(6'd1, 2'd2, 1'b0);
        send_pkt(0, 0, -1, 0, 3'b000);
        idle(2);
        collect();
        checks++;
        if (act_we.size() !== 3 || act_err !== 0) begin
            errors++;
            $display("FAIL rstmid_count got %0d writes err=%0d want 3 writes err=0", act_we.size(), act_err);
        end
        for (int k = 0; k < act_we.size() && k < exp_we.size(); k++) begin
            checks++;
            if ({act_we[k], act_d[k], act_l[k]} !== {exp_we[k], exp_d[k], exp_l[k]}) begin
                errors++;
                $display("FAIL rstmid_wr%0d got we=%b d=%h lfd=%b want we=%b d=%h lfd=%b",
                         k, act_we[k], act_d[k], act_l[k], exp_we[k], exp_d[k], exp_l[k]);
            end
        end
    endtask

    task automatic test_len0();
        clear_trace();
        build_pkt(6'd0, 2'd2, 1'b0);
        send_pkt(0, 0, -1, 0, 3'b000);
        idle(2);
        collect();
        checks++;
        if (act_we.size() !== 2 || act_err !== 0) begin
            errors++;
            $display("FAIL len0_count got %0d writes err=%0d want 2 writes err=0", act_we.size(), act_err);
        end
        for (int k = 0; k < act_we.size() && k < 2; k++) begin
            checks++;
            if ({act_we[k], act_d[k], act_l[k]} !== {3'b100, 8'h02, (k == 0)}) begin
                errors++;
                $display("FAIL len0_wr%0d got we=%b d=%h lfd=%b want we=100 d=02 lfd=%b",
                         k, act_we[k], act_d[k], act_l[k], (k == 0));
            end
        end
    endtask

    task automatic test_random();
        clear_trace();
        for (int p = 0; p < 10; p++) begin
            build_pkt(6'($urandom_range(0, 20)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            send_pkt(20, 25, -1, 0, 3'b000);
        end
        idle(2);
        collect();
        checks++;
        if (act_we.size() !== exp_we.size() || act_err !== exp_err) begin
            errors++;
            $display("FAIL rand_count got %0d writes err=%0d want %0d writes err=%0d",
                     act_we.size(), act_err, exp_we.size(), exp_err);
        end
        for (int k = 0; k < act_we.size() && k < exp_we.size(); k++) begin
            checks++;
            if ({act_we[k], act_d[k], act_l[k]} !== {exp_we[k], exp_d[k], exp_l[k]}) begin
                errors++;
                $display("FAIL rand_wr%0d got we=%b d=%h lfd=%b want we=%b d=%h lfd=%b",
                         k, act_we[k], act_d[k], act_l[k], exp_we[k], exp_d[k], exp_l[k]);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        pkt_valid = 1'b0;
        din       = 8'h00;
        fifo_full = 3'b000;
        @(posedge clk);
        #1;
        test_reset();
        test_good_packet();
        test_bad_parity();
        test_full_stall();
        test_drop();
        test_reset_mid();
        test_len0();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
